// File: rtl/scan_chain_sequencer.sv
// Runs one capture/shift/latch scan-chain transaction per accepted start; ready is low for
// 2*CLK_DIV*(8*NUM_DESIGNS+1)+3 clks. start is ignored while busy, and an out-of-range select is rejected with sel_err.
module scan_chain_sequencer #(
  parameter int NUM_DESIGNS = 100,
  parameter int CLK_DIV     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] active_select,
  input  logic [7:0] inputs,
  output logic [7:0] outputs,
  output logic       ready,
  output logic       sel_err,
  output logic       scan_clk,
  output logic       scan_data_out,
  input  logic       scan_data_in,
  output logic       scan_select,
  output logic       scan_latch_enable
);

  localparam int NBITS = 8 * NUM_DESIGNS;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int GRP_W = CNT_W - 3;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);
  localparam logic [9:0]       NUM_SEL  = 10'(NUM_DESIGNS);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, LATCH, DONE} state_t;

  state_t           state_q, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic             phase_q, phase_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, nk;
  logic [8:0]       sel_q, sel_n;
  logic [7:0]       in_q, in_n, shadow_q, shadow_n, out_n;
  logic             ready_n, err_n, sclk_n, sdo_n, ssel_n, sle_n;
  logic [GRP_W-1:0] tgt;

  // The last design is shifted first, so the selected slot's group index is reversed.
  assign tgt = GRP_W'(10'(NUM_DESIGNS - 1) - {1'b0, sel_q});

  always_comb begin
    state_n  = state_q;
    div_n    = div_q;
    phase_n  = phase_q;
    cnt_n    = cnt_q;
    sel_n    = sel_q;
    in_n     = in_q;
    shadow_n = shadow_q;
    out_n    = outputs;
    ready_n  = ready;
    err_n    = 1'b0;
    sclk_n   = scan_clk;
    sdo_n    = scan_data_out;
    ssel_n   = scan_select;
    sle_n    = 1'b0;
    nk       = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, active_select} < NUM_SEL) begin
            sel_n   = active_select;
            in_n    = inputs;
            ready_n = 1'b0;
            state_n = CAPTURE;
            div_n   = '0;
            phase_n = 1'b0;
            cnt_n   = '0;
            sclk_n  = 1'b0;
            sdo_n   = 1'b0;
            ssel_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      CAPTURE, SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_n = div_q + 1'b1;
        end else begin
          div_n = '0;
          if (!phase_q) begin
            phase_n = 1'b1;
            sclk_n  = 1'b1;
            if (state_q == SHIFT && cnt_q[CNT_W-1:3] == tgt)
              shadow_n[~cnt_q[2:0]] = scan_data_in;
          end else begin
            phase_n = 1'b0;
            sclk_n  = 1'b0;
            if (state_q == SHIFT && cnt_q == CNT_LAST) begin
              state_n = LATCH;
              sdo_n   = 1'b0;
              sle_n   = 1'b1;
            end else begin
              nk      = (state_q == CAPTURE) ? '0 : cnt_q + 1'b1;
              cnt_n   = nk;
              state_n = SHIFT;
              ssel_n  = 1'b0;
              sdo_n   = (nk[CNT_W-1:3] == tgt) ? in_q[~nk[2:0]] : 1'b0;
            end
          end
        end
      end
      LATCH: begin
        // One clk with latch enable high, then one clk low before completing.
        if (!scan_latch_enable) state_n = DONE;
      end
      DONE: begin
        out_n   = shadow_q;
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      div_q             <= '0;
      phase_q           <= 1'b0;
      cnt_q             <= '0;
      sel_q             <= '0;
      in_q              <= '0;
      shadow_q          <= '0;
      outputs           <= '0;
      ready             <= 1'b1;
      sel_err           <= 1'b0;
      scan_clk          <= 1'b0;
      scan_data_out     <= 1'b0;
      scan_select       <= 1'b0;
      scan_latch_enable <= 1'b0;
    end else begin
      state_q           <= state_n;
      div_q             <= div_n;
      phase_q           <= phase_n;
      cnt_q             <= cnt_n;
      sel_q             <= sel_n;
      in_q              <= in_n;
      shadow_q          <= shadow_n;
      outputs           <= out_n;
      ready             <= ready_n;
      sel_err           <= err_n;
      scan_clk          <= sclk_n;
      scan_data_out     <= sdo_n;
      scan_select       <= ssel_n;
      scan_latch_enable <= sle_n;
    end
  end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Bench for scan_chain_sequencer: two-design chain models around a CLK_DIV=1 and a CLK_DIV=3 instance.
module tb_scan_chain_sequencer;

  localparam int ND = 2;
  localparam logic [7:0] D1_A = 8'h3C, D0_A = 8'hFF;
  localparam logic [7:0] D1_B = 8'h5A, D0_B = 8'h96;

  typedef struct {
    logic [7:0]  exp_out;
    logic [15:0] exp_word;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, start3 = 1'b0;
  logic [8:0] sel1 = '0, sel3 = '0;
  logic [7:0] in1 = '0, in3 = '0;
  logic [7:0] out1, out3;
  logic rdy1, err1, sclk1, sdo1, sdi1, ssel1, sle1;
  logic rdy3, err3, sclk3, sdo3, sdi3, ssel3, sle3;

  scan_chain_sequencer #(.NUM_DESIGNS(ND), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .active_select(sel1), .inputs(in1),
    .outputs(out1), .ready(rdy1), .sel_err(err1), .scan_clk(sclk1),
    .scan_data_out(sdo1), .scan_data_in(sdi1), .scan_select(ssel1),
    .scan_latch_enable(sle1)
  );

  scan_chain_sequencer #(.NUM_DESIGNS(ND), .CLK_DIV(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .active_select(sel3), .inputs(in3),
    .outputs(out3), .ready(rdy3), .sel_err(err3), .scan_clk(sclk3),
    .scan_data_out(sdo3), .scan_data_in(sdi3), .scan_select(ssel3),
    .scan_latch_enable(sle3)
  );

  // Chain models: bit 15 is the output end (design 1, bit 7).
  logic [15:0] chain1 = '0, chain3 = '0, latched1 = '0, latched3 = '0;
  logic [15:0] sdo_rec1 = '0, sdo_rec3 = '0;
  int any_rise1 = 0, shift_rise1 = 0, latch_cnt1 = 0, latch_hi1 = 0;
  int latch_cnt3 = 0, lowcnt3 = 0;

  assign sdi1 = chain1[15];
  // Correct only in the clk just before the rise, so off-edge sampling corrupts the result.
  assign sdi3 = (!sclk3 && lowcnt3 == 2) ? chain3[15] : ~chain3[15];

  always @(posedge sclk1) begin
    any_rise1 <= any_rise1 + 1;
    if (ssel1) chain1 <= {D1_A, D0_A};
    else begin
      chain1      <= {chain1[14:0], sdo1};
      sdo_rec1    <= {sdo_rec1[14:0], sdo1};
      shift_rise1 <= shift_rise1 + 1;
    end
  end

  always @(posedge sclk3) begin
    if (ssel3) chain3 <= {D1_B, D0_B};
    else begin
      chain3   <= {chain3[14:0], sdo3};
      sdo_rec3 <= {sdo_rec3[14:0], sdo3};
    end
  end

  always @(posedge sle1) begin
    latched1   <= chain1;
    latch_cnt1 <= latch_cnt1 + 1;
  end
  always @(posedge sle3) begin
    latched3   <= chain3;
    latch_cnt3 <= latch_cnt3 + 1;
  end
  always @(negedge clk) if (sle1) latch_hi1 <= latch_hi1 + 1;
  always @(posedge clk) lowcnt3 <= sclk3 ? 0 : lowcnt3 + 1;

  int n_checks = 0, n_pass = 0;
  int base_latch = 0, base_hi = 0;
  exp_t sb1[$];
  exp_t sb3[$];

  function automatic logic [15:0] exp_word(input logic [8:0] s, input logic [7:0] v);
    logic [15:0] w;
    int d, b;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      d = ND - 1 - k / 8;
      b = 7 - k % 8;
      if (d == int'(s)) w[15-k] = v[b];
    end
    return w;
  endfunction

  task automatic start_txn1(input logic [8:0] s, input logic [7:0] v, input bit push);
    exp_t e;
    @(negedge clk);
    sel1 = s; in1 = v; start1 = 1'b1;
    if (push) begin
      e.exp_out  = (s == 9'd1) ? D1_A : D0_A;
      e.exp_word = exp_word(s, v);
      sb1.push_back(e);
    end
    base_latch = latch_cnt1;
    base_hi    = latch_hi1;
  endtask

  task automatic finish_txn1(input string tag, input bit drop_start);
    int lat;
    bit done;
    exp_t e;
    lat = 0; done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (drop_start) start1 = 1'b0;
      if (rdy1) begin done = 1'b1; break; end
      lat++;
    end
    n_checks++;
    if (!done || lat != 37) $display("FAIL %s busy_cycles: got %0d (done=%0d) expected 37", tag, lat, done);
    else n_pass++;
    n_checks++;
    if (sb1.size() == 0) begin
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
      return;
    end
    n_pass++;
    e = sb1.pop_front();
    n_checks++;
    if (out1 !== e.exp_out) $display("FAIL %s outputs: got %h expected %h", tag, out1, e.exp_out);
    else n_pass++;
    n_checks++;
    if (sdo_rec1 !== e.exp_word) $display("FAIL %s sdo_stream: got %h expected %h", tag, sdo_rec1, e.exp_word);
    else n_pass++;
    n_checks++;
    if (latched1 !== e.exp_word) $display("FAIL %s latched_chain: got %h expected %h", tag, latched1, e.exp_word);
    else n_pass++;
    n_checks++;
    if (latch_cnt1 - base_latch != 1) $display("FAIL %s latch_pulses: got %0d expected 1", tag, latch_cnt1 - base_latch);
    else n_pass++;
    n_checks++;
    if (latch_hi1 - base_hi != 1) $display("FAIL %s latch_width: got %0d expected 1", tag, latch_hi1 - base_hi);
    else n_pass++;
    base_latch = latch_cnt1;
    base_hi    = latch_hi1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (out1 !== 8'h00) $display("FAIL reset outputs: got %h expected 00", out1); else n_pass++;
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL reset ready: got %b expected 1", rdy1); else n_pass++;
    n_checks++; if (err1 !== 1'b0) $display("FAIL reset sel_err: got %b expected 0", err1); else n_pass++;
    n_checks++; if (sclk1 !== 1'b0) $display("FAIL reset scan_clk: got %b expected 0", sclk1); else n_pass++;
    n_checks++; if (sdo1 !== 1'b0) $display("FAIL reset scan_data_out: got %b expected 0", sdo1); else n_pass++;
    n_checks++; if (ssel1 !== 1'b0) $display("FAIL reset scan_select: got %b expected 0", ssel1); else n_pass++;
    n_checks++; if (sle1 !== 1'b0) $display("FAIL reset latch_enable: got %b expected 0", sle1); else n_pass++;
    n_checks++; if (rdy3 !== 1'b1) $display("FAIL reset ready_div3: got %b expected 1", rdy3); else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sel1();
    start_txn1(9'd1, 8'hA5, 1'b1);
    finish_txn1("sel1", 1'b1);
    n_checks++; if (out1 !== 8'h3C) $display("FAIL sel1 outputs_literal: got %h expected 3c", out1); else n_pass++;
    n_checks++; if (sdo_rec1 !== 16'hA500) $display("FAIL sel1 stream_literal: got %h expected a500", sdo_rec1); else n_pass++;
  endtask

  task automatic test_sel0();
    start_txn1(9'd0, 8'h81, 1'b1);
    finish_txn1("sel0", 1'b1);
    n_checks++; if (sdo_rec1 !== 16'h0081) $display("FAIL sel0 stream_literal: got %h expected 0081", sdo_rec1); else n_pass++;
  endtask

  task automatic test_select_error();
    int rises;
    rises = any_rise1;
    @(negedge clk);
    sel1 = 9'd2; in1 = 8'h33; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n_checks++; if (err1 !== 1'b1) $display("FAIL selerr pulse: got %b expected 1", err1); else n_pass++;
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL selerr ready: got %b expected 1", rdy1); else n_pass++;
    @(negedge clk);
    n_checks++; if (err1 !== 1'b0) $display("FAIL selerr pulse_end: got %b expected 0", err1); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL selerr ready_hold: got %b expected 1", rdy1); else n_pass++;
    n_checks++; if (any_rise1 != rises) $display("FAIL selerr scan_clk_rises: got %0d expected %0d", any_rise1, rises); else n_pass++;
    n_checks++; if (out1 !== 8'hFF) $display("FAIL selerr outputs_hold: got %h expected ff", out1); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    int base, lc;
    bit hit;
    base = shift_rise1; hit = 1'b0;
    start_txn1(9'd1, 8'hA5, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (shift_rise1 >= base + 7) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) $display("FAIL midreset reach_pulse7: got %0d shifts expected 7", shift_rise1 - base);
    else n_pass++;
    lc = latch_cnt1;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (sclk1 !== 1'b0) $display("FAIL midreset scan_clk: got %b expected 0", sclk1); else n_pass++;
    n_checks++; if (sdo1 !== 1'b0) $display("FAIL midreset scan_data_out: got %b expected 0", sdo1); else n_pass++;
    n_checks++; if (ssel1 !== 1'b0) $display("FAIL midreset scan_select: got %b expected 0", ssel1); else n_pass++;
    n_checks++; if (out1 !== 8'h00) $display("FAIL midreset outputs: got %h expected 00", out1); else n_pass++;
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL midreset ready: got %b expected 1", rdy1); else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (latch_cnt1 != lc) $display("FAIL midreset latch_pulse: got %0d expected %0d", latch_cnt1, lc); else n_pass++;
    n_checks++; if (rdy1 !== 1'b1) $display("FAIL midreset ready_after: got %b expected 1", rdy1); else n_pass++;
    start_txn1(9'd0, 8'h81, 1'b1);
    finish_txn1("after_reset", 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    start_txn1(9'd1, 8'h0F, 1'b1);
    @(posedge clk);
    #1;
    sel1 = 9'd0; in1 = 8'hF0;
    e.exp_out  = D0_A;
    e.exp_word = exp_word(9'd0, 8'hF0);
    sb1.push_back(e);
    finish_txn1("b2b_first", 1'b0);
    finish_txn1("b2b_second", 1'b1);
  endtask

  task automatic test_clk_div();
    int lat, run, highs, bad, lc;
    bit done;
    logic prev;
    exp_t e;
    lat = 0; run = 0; highs = 0; bad = 0; done = 1'b0; prev = 1'b0;
    lc = latch_cnt3;
    @(negedge clk);
    sel3 = 9'd0; in3 = 8'hC3; start3 = 1'b1;
    e.exp_out  = D0_B;
    e.exp_word = {8'h00, 8'hC3};
    sb3.push_back(e);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (rdy3) begin done = 1'b1; break; end
      lat++;
      if (sclk3 === prev) run++;
      else begin
        if (run != 3) bad++;
        if (prev) highs++;
        prev = sclk3;
        run  = 1;
      end
    end
    e = sb3.pop_front();
    n_checks++; if (!done || lat != 105) $display("FAIL div3 busy_cycles: got %0d expected 105", lat); else n_pass++;
    n_checks++; if (highs != 17) $display("FAIL div3 pulses: got %0d expected 17", highs); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL div3 phase_len: got %0d bad phases expected 0", bad); else n_pass++;
    n_checks++; if (out3 !== e.exp_out) $display("FAIL div3 outputs: got %h expected %h", out3, e.exp_out); else n_pass++;
    n_checks++; if (sdo_rec3 !== e.exp_word) $display("FAIL div3 sdo_stream: got %h expected %h", sdo_rec3, e.exp_word); else n_pass++;
    n_checks++; if (latched3 !== e.exp_word) $display("FAIL div3 latched_chain: got %h expected %h", latched3, e.exp_word); else n_pass++;
    n_checks++; if (latch_cnt3 - lc != 1) $display("FAIL div3 latch_pulses: got %0d expected 1", latch_cnt3 - lc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sel1();
    test_sel0();
    test_select_error();
    test_reset_mid_shift();
    test_back_to_back();
    test_clk_div();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_chain_sequencer.md
Name: scan_chain_sequencer

Overview:
- Runs one complete scan-chain transaction on request, for the chain of NUM_DESIGNS user designs with 8 bits each.
- Transaction order: capture every design's outputs, shift the full chain, then pulse latch.
- During the shift it drives `inputs` into the selected design's slot and zeros into every other slot. It extracts that design's captured outputs from the returning stream.
- Sits between the top-level pad interface and the scan chain.

Parameters:
- NUM_DESIGNS, 100, number of 8-bit design slots in the chain.
- CLK_DIV, 1, clk cycles per scan_clk half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a transaction; sampled only while ready=1.
- active_select  in  9  design index, sampled with start.
- inputs  in  8  value for the selected design, sampled with start.
- outputs  out  8  selected design's captured outputs from the last transaction.
- ready  out  1  idle, able to accept start.
- sel_err  out  1  one-cycle pulse: start rejected because active_select >= NUM_DESIGNS.
- scan_clk  out  1  chain shift clock.
- scan_data_out  out  1  serial data into the chain.
- scan_data_in  in  1  serial data returning from the chain.
- scan_select  out  1  1 = chain flops parallel-capture design outputs on the scan_clk rise.
- scan_latch_enable  out  1  1 = designs load their inputs from the chain.

Behaviour:
- Reset (reset=0, async): state IDLE, counters 0, outputs=0, ready=1, sel_err=0, all scan_* outputs 0.
- FSM states: IDLE -> CAPTURE -> SHIFT -> LATCH -> DONE -> IDLE. All outputs are registered.
- IDLE, start=1, active_select < NUM_DESIGNS:
  - register sel and inputs;
  - ready=0 from the next cycle;
  - enter CAPTURE.
- IDLE, start=1, active_select >= NUM_DESIGNS:
  - sel_err=1 for one cycle;
  - stay in IDLE with ready=1.
- start while ready=0 is ignored.
- scan_clk pulse: low for CLK_DIV clks, then high for CLK_DIV clks.
  - scan_data_out and scan_select change only while scan_clk is low, at the start of the low phase.
  - scan_data_in is sampled on the clk edge that raises scan_clk.
- CAPTURE: one pulse with scan_select=1. Sampled data is discarded.
- SHIFT: exactly 8*NUM_DESIGNS pulses with scan_select=0, shift index k = 0..8*NUM_DESIGNS-1.
  - Slot mapping: index k belongs to design d = NUM_DESIGNS-1-k/8, bit b = 7-(k%8). Bits go MSB first, and the last design is shifted first.
  - scan_data_out = inputs_reg[b] when d == sel, else 0.
  - The bit sampled at index k is design d's output bit b. Bits with d == sel go into a shadow register; all others are dropped.
- LATCH: scan_clk=0; scan_latch_enable=1 for exactly 1 clk, then 0 for 1 clk.
- DONE: outputs <= shadow; ready=1 on the next cycle.
- Latency: ready is low for exactly 2*CLK_DIV*(8*NUM_DESIGNS+1)+3 cycles.
- outputs changes only in DONE and holds between transactions.
- The shift counter is wide enough for 8*NUM_DESIGNS with no wrap. It clears on every accepted start.
- Reset mid-transaction:
  - immediate return to IDLE;
  - all scan_* outputs 0, no latch pulse;
  - outputs=0.
- start on the same cycle that ready returns high is accepted.

Test Plan:
- NUM_DESIGNS=2, CLK_DIV=1; start, sel=1, inputs=0xA5; chain model returns design1 outs=0x3C, design0=0xFF.
  - outputs=0x3C, ready low 37 cycles.
  - scan_data_out stream over 16 pulses = 1,0,1,0,0,1,0,1 then eight 0s.
  - exactly one latch pulse.
- Same setup, sel=0, inputs=0x81: first 8 shifted bits 0, next 8 = 1,0,0,0,0,0,0,1; outputs=0xFF.
- start with active_select=2 (NUM_DESIGNS=2): sel_err one-cycle pulse, ready stays 1, no scan_clk toggles.
- CLK_DIV=3:
  - each scan_clk high and low phase lasts 3 clks;
  - ready low for 2*3*17+3=105 cycles;
  - scan_data_in is sampled only on rising scan_clk.
- Assert reset=0 mid-SHIFT (pulse 7), asynchronously between clk edges:
  - all outputs 0 without waiting for a clk edge;
  - no scan_latch_enable pulse;
  - after release, ready=1 and a new start completes normally.
- Back-to-back: start held high continuously; a second transaction begins the cycle ready returns, and outputs updates after each transaction.
